// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline stall, flush and halt-drain controller
module hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  id_rs_reg,
  input  logic [3:0]  id_rt_reg,
  input  logic        id_uses_rt,
  input  logic        id_hlt,
  input  logic        branch_taken,
  input  logic        ex_memread,
  input  logic [3:0]  ex_rd,
  input  logic        ex_WriteReg,
  input  logic        mem_busy,
  output logic        pc_stall_n,
  output logic        if_id_stall_n,
  output logic        id_ex_stall_n,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        halted,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t     state;
  logic [1:0] drain_cnt;
  logic       load_use;
  logic       hlt_accept;

  // A load in EX whose destination feeds the ID instruction; r0 never carries a dependency
  assign load_use = ex_memread & ex_WriteReg & (ex_rd != 4'd0) &
                    ((ex_rd == id_rs_reg) | (id_uses_rt & (ex_rd == id_rt_reg)));

  // HLT is only taken when nothing of higher priority claims the cycle
  assign hlt_accept = ~mem_busy & ~load_use & ~branch_taken & id_hlt;

  assign halted = (state == HALTED);

  // Pipeline enables and clears, decoded from state and the current hazards
  always_comb begin
    pc_stall_n    = 1'b1;
    if_id_stall_n = 1'b1;
    id_ex_stall_n = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    if (rst) begin
      // Clear both pipeline registers while the PC is loaded with its reset value
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (mem_busy) begin
            pc_stall_n    = 1'b0;
            if_id_stall_n = 1'b0;
            id_ex_stall_n = 1'b0;
          end else if (load_use) begin
            pc_stall_n    = 1'b0;
            if_id_stall_n = 1'b0;
            id_ex_flush   = 1'b1;
          end else if (branch_taken) begin
            if_id_flush = 1'b1;
          end
        end
        DRAIN: begin
          // Stop fetching and let the instructions behind HLT retire
          pc_stall_n  = 1'b0;
          if_id_flush = 1'b1;
          if (mem_busy) begin
            if_id_stall_n = 1'b0;
            id_ex_stall_n = 1'b0;
          end
        end
        HALTED: begin
          pc_stall_n    = 1'b0;
          if_id_stall_n = 1'b0;
          id_ex_stall_n = 1'b0;
        end
        default: begin
          pc_stall_n = 1'b1;
        end
      endcase
    end
  end

  // Run/drain/halt sequencing; draining waits three unstalled cycles for EX, MEM and WB
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      drain_cnt <= 2'd0;
    end else begin
      case (state)
        RUN: begin
          if (hlt_accept) begin
            state     <= DRAIN;
            drain_cnt <= 2'd3;
          end
        end
        DRAIN: begin
          if (!mem_busy) begin
            drain_cnt <= drain_cnt - 2'd1;
            if (drain_cnt <= 2'd1) begin
              state <= HALTED;
            end
          end
        end
        HALTED: begin
          state <= HALTED;
        end
        default: begin
          state     <= RUN;
          drain_cnt <= 2'd0;
        end
      endcase
    end
  end

  // Saturating count of cycles in which the PC did not advance, excluding the halted period
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= 16'd0;
    end else if (!pc_stall_n && (state != HALTED) && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have a single clock and asynchronous, active-high reset; no other clocks or resets.
REQ-002 SHALL have port: clk  in  1  rising-edge clock.
REQ-003 SHALL have port: rst  in  1  asynchronous active-high reset.
REQ-004 SHALL have ports: id_rs_reg  in  4, and id_rt_reg  in  4; these are the source register numbers of the instruction in ID.
REQ-005 SHALL have port: id_uses_rt  in  1  ID instruction reads rt.
REQ-006 SHALL have port: id_hlt  in  1  ID instruction is HLT.
REQ-007 SHALL have port: branch_taken  in  1  ID resolved taken branch.
REQ-008 SHALL have ports: ex_memread  in  1, ex_rd  in  4, ex_WriteReg  in  1; these come from the ID/EX register outputs.
REQ-009 SHALL have port: mem_busy  in  1  instruction or data memory not ready.
REQ-010 SHALL have port: pc_stall_n  out  1  PC write enable.
REQ-011 SHALL have port: if_id_stall_n  out  1  IF/ID write enable.
REQ-012 SHALL have port: id_ex_stall_n  out  1  ID/EX write enable.
REQ-013 SHALL have port: if_id_flush  out  1  IF/ID clear.
REQ-014 SHALL have port: id_ex_flush  out  1  ID/EX clear (bubble insert).
REQ-015 SHALL have port: halted  out  1  core halted.
REQ-016 SHALL have port: stall_cnt  out  16  stall-cycle counter.

Function
REQ-017 SHALL implement states RUN, DRAIN and HALTED, held in a register.
REQ-018 SHALL define the internal signal load_use as ex_memread & ex_WriteReg & (ex_rd!=0) & ((ex_rd==id_rs_reg) | (id_uses_rt & ex_rd==id_rt_reg)).
REQ-019 SHALL have a default output set of all stall_n=1, both flush=0, halted=0.
REQ-020 SHALL apply, in RUN with mem_busy=1: all three stall_n=0 and both flush=0 (pipeline frozen); the state is held.
REQ-021 SHALL apply, in RUN with mem_busy=0 and load_use=1: pc_stall_n=0, if_id_stall_n=0, id_ex_stall_n=1, id_ex_flush=1 (exactly one bubble); branch_taken and id_hlt are ignored in that cycle.
REQ-022 SHALL apply, in RUN with mem_busy=0, load_use=0 and branch_taken=1: if_id_flush=1.
REQ-023 SHALL, in RUN with mem_busy=0, load_use=0 and id_hlt=1, transition to DRAIN and load drain_cnt=3 on the next edge; HLT itself advances into ID/EX normally.
REQ-024 SHALL apply, in DRAIN: pc_stall_n=0 and if_id_flush=1.
REQ-025 SHALL, in DRAIN with mem_busy=1, additionally drive if_id_stall_n=0 and id_ex_stall_n=0 and hold drain_cnt.
REQ-026 SHALL, in DRAIN with mem_busy=0, decrement drain_cnt; a cycle with drain_cnt==1 transitions to HALTED.
REQ-027 SHALL apply, in HALTED: halted=1, all stall_n=0 and both flush=0; the only exit from HALTED is rst.
REQ-028 SHALL increment stall_cnt by 1 on every edge where pc_stall_n=0 and the state is not HALTED, saturating at 16'hFFFF.
REQ-029 SHALL implement all outputs except stall_cnt and halted as combinational from state and inputs; halted SHALL decode state only.
REQ-030 SHALL apply the priority mem_busy > load_use > branch_taken > id_hlt.

Reset
REQ-031 SHALL, on rst=1 (asynchronous), immediately force state=RUN, drain_cnt=0, stall_cnt=0 and halted=0.
REQ-032 SHALL, while rst=1, drive pc_stall_n=1, if_id_flush=1 and id_ex_flush=1.
REQ-033 SHALL abort a DRAIN or HALTED state when rst is asserted, with the block in RUN after rst is released.

Verification
REQ-034 SHALL pass this scenario: ex_memread=1, ex_WriteReg=1, ex_rd=5, id_rs_reg=5 -> for one cycle pc_stall_n=0, id_ex_flush=1, stall_cnt=1; no stall on the next cycle once ex_memread=0.
REQ-035 SHALL pass this scenario: the same as REQ-034 with ex_rd=0, or id_rt_reg=5 with id_uses_rt=0 -> no stall, stall_cnt=0.
REQ-036 SHALL pass this scenario: load_use=1 and branch_taken=1 together -> bubble only, if_id_flush=0.
REQ-037 SHALL pass this scenario: id_hlt=1 in RUN, then mem_busy=1 for 2 cycles inside DRAIN -> halted=1 exactly 5 edges after the HLT cycle, stall_cnt=5, stall_cnt frozen afterward.
REQ-038 SHALL pass this scenario: mem_busy=1 for 4 cycles in RUN -> all stall_n=0 for 4 cycles, stall_cnt=4.
REQ-039 SHALL pass this scenario: rst pulsed mid-DRAIN, not clock-aligned -> state=RUN and stall_cnt=0 without waiting for an edge; stall_cnt saturates at FFFF under a continuous stall.
